// File: rtl/register_file.sv
// register_file: 32-entry operand store with one synchronous write port and two
// independently enabled combinational read ports; reset clears every entry.
module register_file #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 5
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 WriteEn,
    input  logic [ADDRWIDTH-1:0] WriteAddr,
    input  logic [DATAWIDTH-1:0] data_i,
    input  logic                 ReadAEn,
    input  logic [ADDRWIDTH-1:0] ReadA,
    output logic [DATAWIDTH-1:0] data_oA,
    input  logic                 ReadBEn,
    input  logic [ADDRWIDTH-1:0] ReadB,
    output logic [DATAWIDTH-1:0] data_oB
);
    localparam int DEPTH = 2 ** ADDRWIDTH;

    logic [DATAWIDTH-1:0] regs_q [DEPTH];

    // Reset has priority over a same-cycle write and clears without a clock edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (WriteEn) begin
            regs_q[WriteAddr] <= data_i;
        end
    end

    // No write bypass: a colliding read sees the new value only after the edge.
    always_comb begin
        data_oA = ReadAEn ? regs_q[ReadA] : '0;
        data_oB = ReadBEn ? regs_q[ReadB] : '0;
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file; a reference array tracks
// every committed write and expected read data is queued before each sample.
module tb_register_file;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        WriteEn;
    logic [4:0]  WriteAddr;
    logic [31:0] data_i;
    logic        ReadAEn;
    logic [4:0]  ReadA;
    logic [31:0] data_oA;
    logic        ReadBEn;
    logic [4:0]  ReadB;
    logic [31:0] data_oB;

    int tests = 0;
    int fails = 0;
    logic [31:0] model [32];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] ea, eb;

    register_file dut (
        .Clk(Clk), .Rst(Rst), .WriteEn(WriteEn), .WriteAddr(WriteAddr), .data_i(data_i),
        .ReadAEn(ReadAEn), .ReadA(ReadA), .data_oA(data_oA),
        .ReadBEn(ReadBEn), .ReadB(ReadB), .data_oB(data_oB)
    );

    always #5 Clk = ~Clk;

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge Clk);
        WriteEn = 1'b1;
        WriteAddr = addr;
        data_i = data;
        @(posedge Clk);
        model[addr] = data;
        #1 WriteEn = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; WriteEn = 1'b0; WriteAddr = '0; data_i = '0;
        ReadAEn = 1'b1; ReadBEn = 1'b1; ReadA = '0; ReadB = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        #12 Rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ReadA = 5'(a); ReadB = 5'(31 - a);
            qa.push_back(32'h0); qb.push_back(32'h0);
            #1;
            ea = qa.pop_front(); eb = qb.pop_front();
            tests++;
            if (data_oA !== ea || data_oB !== eb) begin
                fails++;
                $display("FAIL reset_read addr=%0d A=%h B=%h expected %h/%h", a, data_oA, data_oB, ea, eb);
            end
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i));
        ReadAEn = 1'b1; ReadBEn = 1'b0;
        for (int a = 0; a < 31; a++) begin
            ReadA = 5'(a);
            qa.push_back(32'(a));
            #1;
            ea = qa.pop_front();
            tests++;
            if (data_oA !== ea) begin
                fails++;
                $display("FAIL write_read_A addr=%0d got %h expected %h", a, data_oA, ea);
            end
        end
        ReadBEn = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ReadB = 5'(a);
            qb.push_back(32'(a));
            #1;
            eb = qb.pop_front();
            tests++;
            if (data_oB !== eb) begin
                fails++;
                $display("FAIL write_read_B addr=%0d got %h expected %h", a, data_oB, eb);
            end
        end
    endtask

    task automatic test_random_data();
        for (int i = 0; i < 32; i++) do_write(5'(i), $urandom);
        ReadAEn = 1'b1; ReadBEn = 1'b1;
        for (int n = 0; n < 64; n++) begin
            ReadA = 5'($urandom_range(31)); ReadB = 5'($urandom_range(31));
            qa.push_back(model[ReadA]); qb.push_back(model[ReadB]);
            #1;
            ea = qa.pop_front(); eb = qb.pop_front();
            tests++;
            if (data_oA !== ea || data_oB !== eb) begin
                fails++;
                $display("FAIL random_read A[%0d]=%h B[%0d]=%h expected %h/%h", ReadA, data_oA, ReadB, data_oB, ea, eb);
            end
        end
    endtask

    task automatic test_read_enable();
        ReadAEn = 1'b0; ReadBEn = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ReadA = 5'(a); ReadB = 5'(a ^ 5);
            qa.push_back(32'h0); qb.push_back(32'h0);
            #1;
            ea = qa.pop_front(); eb = qb.pop_front();
            tests++;
            if (data_oA !== ea || data_oB !== eb) begin
                fails++;
                $display("FAIL read_disabled addr=%0d A=%h B=%h expected %h/%h", a, data_oA, data_oB, ea, eb);
            end
        end
        ReadA = 5'd9; ReadB = 5'd22;
        ReadAEn = 1'b1; ReadBEn = 1'b1;
        qa.push_back(model[9]); qb.push_back(model[22]);
        #1;
        ea = qa.pop_front(); eb = qb.pop_front();
        tests++;
        if (data_oA !== ea || data_oB !== eb) begin
            fails++;
            $display("FAIL read_reenable A=%h B=%h expected %h/%h", data_oA, data_oB, ea, eb);
        end
    endtask

    task automatic test_collision();
        ReadAEn = 1'b1; ReadA = 5'd7;
        @(negedge Clk);
        WriteEn = 1'b1; WriteAddr = 5'd7; data_i = 32'hDEADBEEF;
        qa.push_back(model[7]);
        #1;
        ea = qa.pop_front();
        tests++;
        if (data_oA !== ea) begin
            fails++;
            $display("FAIL collision_before got %h expected %h", data_oA, ea);
        end
        @(posedge Clk);
        model[7] = 32'hDEADBEEF;
        qa.push_back(32'hDEADBEEF);
        #1;
        ea = qa.pop_front();
        tests++;
        if (data_oA !== ea) begin
            fails++;
            $display("FAIL collision_after got %h expected %h", data_oA, ea);
        end
        WriteEn = 1'b0; data_i = 32'hCAFEF00D;
        @(posedge Clk);
        qa.push_back(32'hDEADBEEF);
        #1;
        ea = qa.pop_front();
        tests++;
        if (data_oA !== ea) begin
            fails++;
            $display("FAIL write_disabled got %h expected %h", data_oA, ea);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i) | 32'h100);
        ReadAEn = 1'b1; ReadBEn = 1'b1;
        @(negedge Clk);
        WriteEn = 1'b1; WriteAddr = 5'd3; data_i = 32'hFFFF_FFFF;
        #2 Rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int a = 0; a < 32; a++) begin
            ReadA = 5'(a); ReadB = 5'd3;
            qa.push_back(32'h0); qb.push_back(32'h0);
            #1;
            ea = qa.pop_front(); eb = qb.pop_front();
            tests++;
            if (data_oA !== ea || data_oB !== eb) begin
                fails++;
                $display("FAIL reset_midop addr=%0d A=%h B(3)=%h expected %h/%h", a, data_oA, data_oB, ea, eb);
            end
        end
        @(negedge Clk);
        WriteEn = 1'b0;
        Rst = 1'b0;
        do_write(5'd3, 32'hA5A5_5A5A);
        ReadA = 5'd3; ReadB = 5'd4;
        qa.push_back(32'hA5A5_5A5A); qb.push_back(32'h0);
        #1;
        ea = qa.pop_front(); eb = qb.pop_front();
        tests++;
        if (data_oA !== ea || data_oB !== eb) begin
            fails++;
            $display("FAIL reset_release A=%h B=%h expected %h/%h", data_oA, data_oB, ea, eb);
        end
    endtask

    task automatic test_same_addr();
        do_write(5'd5, 32'h12345678);
        ReadAEn = 1'b1; ReadBEn = 1'b1; ReadA = 5'd5; ReadB = 5'd5;
        qa.push_back(32'h12345678); qb.push_back(32'h12345678);
        #1;
        ea = qa.pop_front(); eb = qb.pop_front();
        tests++;
        if (data_oA !== ea || data_oB !== eb) begin
            fails++;
            $display("FAIL same_addr A=%h B=%h expected %h/%h", data_oA, data_oB, ea, eb);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_random_data();
        test_read_enable();
        test_collision();
        test_reset_midop();
        test_same_addr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
